alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 183 ++++++++++++++++++
 tb/tb_alarm_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm controller: stores an alarm time, rings on the matching minute, and
// handles snooze/stop/auto-stop with per-event snooze limiting.
module alarm_controller #(
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic       arm_en,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  output logic       set_ready,
  output logic       set_err,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ring,
  output logic [1:0] state,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [2:0] snooze_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } state_t;

  localparam logic [6:0] RING_LOAD   = 7'(RING_TIMEOUT);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
  localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

  state_t     state_r, state_s;
  logic [6:0] ring_timer_r, ring_timer_s;
  logic [9:0] snooze_timer_r, snooze_timer_s;
  logic [2:0] snooze_count_r, snooze_count_s;
  logic       fired_r, fired_s;
  logic       ring_r, set_ready_r, set_err_r;
  logic [4:0] alarm_hours_r;
  logic [5:0] alarm_minutes_r;

  logic time_match_s, trigger_s, xfer_s, set_ok_s;

  assign time_match_s = (cur_hours == alarm_hours_r) && (cur_minutes == alarm_minutes_r);
  assign trigger_s    = tick_1hz && time_match_s && (cur_seconds == 6'd0) && !fired_r;
  assign xfer_s       = set_valid && set_ready_r;
  assign set_ok_s     = (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  // fired_r blocks a second trigger until the clock leaves the alarm minute
  always_comb begin
    fired_s = fired_r;
    if (!time_match_s) begin
      fired_s = 1'b0;
    end else if (trigger_s) begin
      fired_s = 1'b1;
    end else begin
      fired_s = fired_r;
    end
  end

  // Next-state and timer/counter logic; arm_en low overrides everything
  always_comb begin
    state_s        = state_r;
    ring_timer_s   = ring_timer_r;
    snooze_timer_s = snooze_timer_r;
    snooze_count_s = snooze_count_r;
    if (!arm_en) begin
      state_s        = IDLE;
      ring_timer_s   = 7'd0;
      snooze_timer_s = 10'd0;
      snooze_count_s = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s        = ARMED;
          snooze_count_s = 3'd0;
        end
        ARMED: begin
          snooze_count_s = 3'd0;
          if (trigger_s) begin
            state_s      = RINGING;
            ring_timer_s = RING_LOAD;
          end else begin
            state_s = ARMED;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state_s        = ARMED;
            snooze_count_s = 3'd0;
            ring_timer_s   = 7'd0;
          end else if (snooze_btn && (snooze_count_r < MAX_CNT)) begin
            state_s        = SNOOZED;
            snooze_count_s = snooze_count_r + 3'd1;
            snooze_timer_s = SNOOZE_LOAD;
            ring_timer_s   = 7'd0;
          end else if (tick_1hz) begin
            if (ring_timer_r <= 7'd1) begin
              state_s        = ARMED;
              snooze_count_s = 3'd0;
              ring_timer_s   = 7'd0;
            end else begin
              ring_timer_s = ring_timer_r - 7'd1;
            end
          end else begin
            state_s = RINGING;
          end
        end
        SNOOZED: begin
          if (stop_btn) begin
            state_s        = ARMED;
            snooze_count_s = 3'd0;
            snooze_timer_s = 10'd0;
          end else if (tick_1hz) begin
            if (snooze_timer_r <= 10'd1) begin
              state_s        = RINGING;
              ring_timer_s   = RING_LOAD;
              snooze_timer_s = 10'd0;
            end else begin
              snooze_timer_s = snooze_timer_r - 10'd1;
            end
          end else begin
            state_s = SNOOZED;
          end
        end
        default: begin
          state_s        = IDLE;
          ring_timer_s   = 7'd0;
          snooze_timer_s = 10'd0;
          snooze_count_s = 3'd0;
        end
      endcase
    end
  end

  // State register and registered outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      ring_timer_r    <= 7'd0;
      snooze_timer_r  <= 10'd0;
      snooze_count_r  <= 3'd0;
      fired_r         <= 1'b0;
      ring_r          <= 1'b0;
      set_ready_r     <= 1'b1;
      set_err_r       <= 1'b0;
      alarm_hours_r   <= 5'd0;
      alarm_minutes_r <= 6'd0;
    end else begin
      state_r        <= state_s;
      ring_timer_r   <= ring_timer_s;
      snooze_timer_r <= snooze_timer_s;
      snooze_count_r <= snooze_count_s;
      fired_r        <= fired_s;
      ring_r         <= (state_s == RINGING);
      set_ready_r    <= (state_s == IDLE) || (state_s == ARMED);
      set_err_r      <= xfer_s && !set_ok_s;
      if (xfer_s && set_ok_s) begin
        alarm_hours_r   <= set_hours;
        alarm_minutes_r <= set_minutes;
      end else begin
        alarm_hours_r   <= alarm_hours_r;
        alarm_minutes_r <= alarm_minutes_r;
      end
    end
  end

  assign state         = state_r;
  assign ring          = ring_r;
  assign set_ready     = set_ready_r;
  assign set_err       = set_err_r;
  assign alarm_hours   = alarm_hours_r;
  assign alarm_minutes = alarm_minutes_r;
  assign snooze_count  = snooze_count_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: a vector table for single-cycle
// behaviour plus sequences for auto-stop, repeated snooze and reset.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;
  logic       arm_en, set_valid;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       set_ready, set_err, snooze_btn, stop_btn, ring;
  logic [1:0] state;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [2:0] snooze_count;

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .arm_en(arm_en), .set_valid(set_valid), .set_hours(set_hours),
    .set_minutes(set_minutes), .set_ready(set_ready), .set_err(set_err),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .ring(ring), .state(state),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arm, sv;
    logic [4:0] sh;
    logic [5:0] sm;
    logic       tk;
    logic [4:0] ch;
    logic [5:0] cm, cs;
    logic       snz, stp;
    logic [1:0] e_st;
    logic       e_rg, e_rdy, e_err;
    logic [4:0] e_ah;
    logic [5:0] e_am;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one tick cycle followed by one quiet cycle
  task automatic tick_pulse(input int h, input int m, input int s);
    tick_1hz = 1'b1;
    cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic chk_all(input string nm, input int st, input int rg, input int rdy,
                         input int err, input int ah, input int am, input int cnt);
    chk({nm, ".state"}, int'(state), st);
    chk({nm, ".ring"}, int'(ring), rg);
    chk({nm, ".set_ready"}, int'(set_ready), rdy);
    chk({nm, ".set_err"}, int'(set_err), err);
    chk({nm, ".alarm_hours"}, int'(alarm_hours), ah);
    chk({nm, ".alarm_minutes"}, int'(alarm_minutes), am);
    chk({nm, ".snooze_count"}, int'(snooze_count), cnt);
  endtask

  initial begin
    //          arm  sv   sh     sm     tk   ch    cm     cs     snz  stp  | st    rg   rdy  err  ah    am     cnt
    vecs[0]  = '{1'b0,1'b0,5'd0, 6'd0, 1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd0,1'b0,1'b1,1'b0,5'd0,6'd0, 3'd0};
    vecs[1]  = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd0,6'd0, 3'd0};
    vecs[2]  = '{1'b1,1'b1,5'd6, 6'd30,1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[3]  = '{1'b1,1'b1,5'd24,6'd10,1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b1,5'd6,6'd30,3'd0};
    vecs[4]  = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[5]  = '{1'b1,1'b1,5'd12,6'd60,1'b0,5'd0,6'd0, 6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b1,5'd6,6'd30,3'd0};
    vecs[6]  = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd29,6'd59,1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[7]  = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd30,6'd0, 1'b0,1'b0, 2'd2,1'b1,1'b0,1'b0,5'd6,6'd30,3'd0};
    vecs[8]  = '{1'b1,1'b1,5'd7, 6'd0, 1'b0,5'd6,6'd30,6'd0, 1'b0,1'b0, 2'd2,1'b1,1'b0,1'b0,5'd6,6'd30,3'd0};
    vecs[9]  = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd30,6'd1, 1'b0,1'b0, 2'd2,1'b1,1'b0,1'b0,5'd6,6'd30,3'd0};
    vecs[10] = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd30,6'd1, 1'b1,1'b0, 2'd3,1'b0,1'b0,1'b0,5'd6,6'd30,3'd1};
    vecs[11] = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd30,6'd1, 1'b1,1'b0, 2'd3,1'b0,1'b0,1'b0,5'd6,6'd30,3'd1};
    vecs[12] = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd30,6'd1, 1'b0,1'b1, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[13] = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd30,6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[14] = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd31,6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd30,3'd0};
    vecs[15] = '{1'b1,1'b1,5'd6, 6'd31,1'b0,5'd6,6'd31,6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd31,3'd0};
    vecs[16] = '{1'b1,1'b0,5'd0, 6'd0, 1'b1,5'd6,6'd31,6'd0, 1'b0,1'b0, 2'd2,1'b1,1'b0,1'b0,5'd6,6'd31,3'd0};
    vecs[17] = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd31,6'd0, 1'b1,1'b1, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd31,3'd0};
    vecs[18] = '{1'b0,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd31,6'd0, 1'b0,1'b0, 2'd0,1'b0,1'b1,1'b0,5'd6,6'd31,3'd0};
    vecs[19] = '{1'b1,1'b0,5'd0, 6'd0, 1'b0,5'd6,6'd31,6'd0, 1'b0,1'b0, 2'd1,1'b0,1'b1,1'b0,5'd6,6'd31,3'd0};

    rst_n = 1'b0; tick_1hz = 1'b0; arm_en = 1'b0; set_valid = 1'b0;
    set_hours = 5'd0; set_minutes = 6'd0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd0;
    #22;
    chk_all("reset", 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      arm_en = vecs[i].arm; set_valid = vecs[i].sv;
      set_hours = vecs[i].sh; set_minutes = vecs[i].sm;
      tick_1hz = vecs[i].tk; cur_hours = vecs[i].ch;
      cur_minutes = vecs[i].cm; cur_seconds = vecs[i].cs;
      snooze_btn = vecs[i].snz; stop_btn = vecs[i].stp;
      step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_st), int'(vecs[i].e_rg),
              int'(vecs[i].e_rdy), int'(vecs[i].e_err), int'(vecs[i].e_ah),
              int'(vecs[i].e_am), int'(vecs[i].e_cnt));
    end
    tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; set_valid = 1'b0;

    // auto-stop after RING_TIMEOUT ticks
    set_valid = 1'b1; set_hours = 5'd6; set_minutes = 6'd30;
    cur_hours = 5'd5; cur_minutes = 6'd0; cur_seconds = 6'd0;
    step();
    set_valid = 1'b0;
    tick_pulse(6, 30, 0);
    chk("timeout.ring_start", int'(ring), 1);
    for (int s = 1; s < 60; s++) tick_pulse(6, 30, s);
    chk("timeout.ring_tick59", int'(ring), 1);
    chk("timeout.state_tick59", int'(state), 2);
    tick_pulse(6, 31, 0);
    chk("timeout.ring_tick60", int'(ring), 0);
    chk("timeout.state_tick60", int'(state), 1);

    // three snoozes, then a fourth press is ignored
    set_valid = 1'b1; set_hours = 5'd7; set_minutes = 6'd0;
    step();
    set_valid = 1'b0;
    tick_pulse(7, 0, 0);
    chk("snz.ring_start", int'(ring), 1);
    for (int k = 1; k <= 3; k++) begin
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      chk($sformatf("snz%0d.state", k), int'(state), 3);
      chk($sformatf("snz%0d.count", k), int'(snooze_count), k);
      chk($sformatf("snz%0d.ring", k), int'(ring), 0);
      for (int t = 1; t < 540; t++) tick_pulse(8, 0, 1);
      chk($sformatf("snz%0d.state_t539", k), int'(state), 3);
      tick_pulse(8, 0, 1);
      chk($sformatf("snz%0d.ring_t540", k), int'(ring), 1);
      chk($sformatf("snz%0d.state_t540", k), int'(state), 2);
    end
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    chk("snz4.state", int'(state), 2);
    chk("snz4.ring", int'(ring), 1);
    chk("snz4.count", int'(snooze_count), 3);
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    chk("stop.state", int'(state), 1);
    chk("stop.count", int'(snooze_count), 0);

    // drop arm_en while snoozed
    tick_pulse(7, 0, 0);
    chk("disarm.ring_start", int'(ring), 1);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    chk("disarm.snoozed", int'(state), 3);
    arm_en = 1'b0;
    step();
    chk_all("disarm", 0, 0, 1, 0, 7, 0, 0);
    arm_en = 1'b1;
    step();
    chk("rearm.state", int'(state), 1);

    // asynchronous reset in the middle of a ring
    cur_hours = 5'd7; cur_minutes = 6'd1; cur_seconds = 6'd0;
    step();
    tick_pulse(7, 0, 0);
    chk("rstring.ring_start", int'(ring), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid_ring", 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst.state", int'(state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
